button_debounce: RTL and testbench

- Conditions a raw mechanical input (push-button, switch, encoder contact) into a clean, glitch-free level.
- Sits directly upstream of the edge detector: `dout` feeds the detector's `din`, which then produces single-cycle press/release pulses.
- Adds a long-press indicator so the UI layer (LCD/OLED menus, ADC/DAC setting changes) can distinguish tap from hold.

---
 rtl/button_debounce.sv | 102 ++++++++++
 tb/tb_button_debounce.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizer, debounce FSM and long-press detector for a raw contact input
// A level change is accepted only after DEBOUNCE_CYCLES stable samples; hold flags a long press.
module button_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter bit INVERT          = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic hold,
   output logic bouncing
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE0, WAIT1, IDLE1, WAIT0} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [HW-1:0]          hcnt, hcnt_nxt;
   logic                   dout_nxt, hold_nxt;

   // Inversion sits after the synchronizer so the flops only ever see the raw pin.
   assign s        = sync[SYNC_STAGES-1] ^ INVERT;
   assign bouncing = (state == WAIT1) || (state == WAIT0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync  <= {SYNC_STAGES{INVERT}};
         state <= IDLE0;
         cnt   <= '0;
         hcnt  <= '0;
         dout  <= 1'b0;
         hold  <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], din};
         state <= state_nxt;
         cnt   <= cnt_nxt;
         hcnt  <= hcnt_nxt;
         dout  <= dout_nxt;
         hold  <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hcnt_nxt  = hcnt;
      dout_nxt  = dout;
      hold_nxt  = hold;
      case (state)
         IDLE0: begin
            if (s) begin
               state_nxt = WAIT1;
               cnt_nxt   = '0;
            end
         end
         WAIT1: begin
            if (!s) begin
               state_nxt = IDLE0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE1;
               dout_nxt  = 1'b1;
               hcnt_nxt  = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         IDLE1: begin
            if (!s) begin
               state_nxt = WAIT0;
               cnt_nxt   = '0;
            end else if (HOLD_CYCLES > 0) begin
               // hcnt parks at HOLD_LAST so hold stays asserted for an arbitrarily long press
               if (hcnt == HOLD_LAST) hold_nxt = 1'b1;
               else                   hcnt_nxt = hcnt + HW'(1);
            end
         end
         WAIT0: begin
            if (s) begin
               state_nxt = IDLE1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE0;
               dout_nxt  = 1'b0;
               hold_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE0;
      endcase
   end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce
// Reference model: dout flips once the synchronized input has disagreed with it for DEBOUNCE+1 consecutive edges.
module tb_button_debounce;

   localparam int SYNC  = 2;
   localparam int DEB   = 4;
   localparam int HOLDC = 10;

   logic clk = 1'b0;
   logic rst_n, din, din_i;
   logic dout, hold, bouncing;
   logic dout_i, hold_i, bouncing_i;

   int checks   = 0;
   int failures = 0;

   bit hist [SYNC];
   bit m_s, m_dout, m_hold;
   int run, q;

   always #5 clk = ~clk;

   button_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLDC), .INVERT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .hold(hold), .bouncing(bouncing));

   button_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLDC), .INVERT(1'b1)) dut_inv (
      .clk(clk), .rst_n(rst_n), .din(din_i), .dout(dout_i), .hold(hold_i), .bouncing(bouncing_i));

   // Advance one clock; the model consumes the same inputs the DUT sampled, then outputs are read at negedge.
   task automatic tick;
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < SYNC; k++) hist[k] = 1'b0;
         run = 0; q = 0; m_dout = 1'b0; m_hold = 1'b0;
      end else begin
         m_s = hist[SYNC-1];
         if (m_s != m_dout) begin
            run++;
            if (run == DEB + 1) begin
               m_dout = m_s;
               run    = 0;
               if (m_s) q = 0;
               else     m_hold = 1'b0;
            end
         end else begin
            if (m_dout && run == 0 && q < HOLDC) begin
               q++;
               if (q == HOLDC) m_hold = 1'b1;
            end
            run = 0;
         end
         for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = din;
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      int first;
      rst_n = 1'b0; din = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if ({dout, hold, bouncing} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs cycle %0d: got d/h/b=%b%b%b expected 000", i, dout, hold, bouncing);
         end
      end
      rst_n = 1'b1;
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         tick;
         if (first == 0 && dout === 1'b1) first = i;
      end
      checks++;
      if (first !== 7) begin
         failures++;
         $display("FAIL reset_release_latency: got dout rise at edge %0d expected 7", first);
      end
   endtask

   task automatic test_clean_press;
      logic [2:0] exp;
      rst_n = 1'b0; din = 1'b0; tick;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick;
      din = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick;
         exp = {(i >= 3 && i <= 6), (i >= 7), (i >= 17)};
         checks++;
         if ({bouncing, dout, hold} !== exp) begin
            failures++;
            $display("FAIL clean_press edge %0d: got b/d/h=%b%b%b expected %b", i, bouncing, dout, hold, exp);
         end
      end
   endtask

   task automatic test_release_after_hold;
      logic [1:0] exp;
      din = 1'b0; tick; tick;
      din = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick;
         checks++;
         if ({dout, hold} !== 2'b11) begin
            failures++;
            $display("FAIL hold_glitch edge %0d: got d/h=%b%b expected 11", i, dout, hold);
         end
      end
      din = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick;
         exp = (i < 7) ? 2'b11 : 2'b00;
         checks++;
         if ({dout, hold} !== exp) begin
            failures++;
            $display("FAIL release_after_hold edge %0d: got d/h=%b%b expected %b", i, dout, hold, exp);
         end
      end
   endtask

   task automatic test_glitch;
      logic [2:0] exp;
      for (int i = 0; i < 3; i++) tick;
      for (int i = 1; i <= 10; i++) begin
         din = (i <= 2);
         tick;
         exp = {(i == 3 || i == 4), 2'b00};
         checks++;
         if ({bouncing, dout, hold} !== exp) begin
            failures++;
            $display("FAIL glitch_reject edge %0d: got b/d/h=%b%b%b expected %b", i, bouncing, dout, hold, exp);
         end
      end
   endtask

   task automatic test_bounce;
      for (int i = 1; i <= 12; i++) begin
         din = (((i - 1) / 2) % 2 == 0);
         tick;
         checks++;
         if (dout !== 1'b0) begin
            failures++;
            $display("FAIL bounce_hold_low edge %0d: got dout=%b expected 0", i, dout);
         end
      end
      din = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         tick;
         checks++;
         if (dout !== (j >= 7)) begin
            failures++;
            $display("FAIL bounce_settle edge %0d: got dout=%b expected %b", j, dout, (j >= 7));
         end
      end
   endtask

   task automatic test_reset_mid_wait;
      int first;
      din = 1'b0; rst_n = 1'b0; tick;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick;
      din = 1'b1;
      for (int i = 0; i < 4; i++) tick;
      checks++;
      if (bouncing !== 1'b1) begin
         failures++;
         $display("FAIL mid_wait_precondition: got bouncing=%b expected 1", bouncing);
      end
      rst_n = 1'b0; tick;
      checks++;
      if ({bouncing, dout, hold} !== 3'b000) begin
         failures++;
         $display("FAIL mid_wait_abort: got b/d/h=%b%b%b expected 000", bouncing, dout, hold);
      end
      rst_n = 1'b1;
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         tick;
         if (first == 0 && dout === 1'b1) first = i;
      end
      checks++;
      if (first !== 7) begin
         failures++;
         $display("FAIL mid_wait_restart: got dout rise at edge %0d expected 7", first);
      end
   endtask

   task automatic test_invert;
      checks++;
      if ({dout_i, hold_i, bouncing_i} !== 3'b000) begin
         failures++;
         $display("FAIL invert_idle: got d/h/b=%b%b%b expected 000", dout_i, hold_i, bouncing_i);
      end
      din_i = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick;
         checks++;
         if (dout_i !== (i >= 7)) begin
            failures++;
            $display("FAIL invert_press edge %0d: got dout=%b expected %b", i, dout_i, (i >= 7));
         end
      end
   endtask

   task automatic test_random;
      logic lvl;
      int   len;
      bit   do_rst;
      rst_n = 1'b0; din = 1'b0; tick;
      rst_n = 1'b1;
      lvl = 1'($urandom_range(0, 1));
      for (int seg = 0; seg < 200; seg++) begin
         lvl    = ~lvl;
         len    = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 7);
         do_rst = ($urandom_range(0, 39) == 0);
         for (int c = 0; c < len; c++) begin
            din   = lvl;
            rst_n = !(do_rst && c == 0);
            tick;
            checks++;
            if ({dout, hold, bouncing} !== {m_dout, m_hold, (run != 0)}) begin
               failures++;
               $display("FAIL random seg %0d cyc %0d: got d/h/b=%b%b%b expected %b%b%b",
                        seg, c, dout, hold, bouncing, m_dout, m_hold, (run != 0));
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; din = 1'b0; din_i = 1'b1;
      test_reset;
      test_clean_press;
      test_release_after_hold;
      test_glitch;
      test_bounce;
      test_reset_mid_wait;
      test_invert;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
